keypad_scan_debounce: RTL and testbench



---
 rtl/lock_pkg.sv | 41 ++++
 rtl/scan_tick_gen.sv | 20 ++
 rtl/keypad_scan_debounce.sv | 142 ++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared keypad/lock definitions: key codes, scanner FSM states, column reset value
// and small decode helpers.
package lock_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, HOLD} state_t;

  localparam logic [2:0] COL_RST = 3'b001;

  localparam logic [3:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8, KEY_9 = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA, KEY_HASH = 4'hB;

  // Index of the set bit in a one-hot vector (bit 3 unused for 3-bit columns).
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = KEY_1;
      4'b00_01: k = KEY_2;
      4'b00_10: k = KEY_3;
      4'b01_00: k = KEY_4;
      4'b01_01: k = KEY_5;
      4'b01_10: k = KEY_6;
      4'b10_00: k = KEY_7;
      4'b10_01: k = KEY_8;
      4'b10_10: k = KEY_9;
      4'b11_00: k = KEY_STAR;
      4'b11_10: k = KEY_HASH;
      default:  k = KEY_0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks (terminal count DIV-1).
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/keypad_scan_debounce.sv
// 3x4 keypad scanner with press/release debounce; one key_flag strobe per press.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module keypad_scan_debounce
  import lock_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEB_TICKS    = 4,
  parameter int REPEAT_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       key_flag,
  output logic [3:0] key_value,
  output logic       key_held
);
  localparam int CW = $clog2(DEB_TICKS + 1);

  if (DEB_TICKS < 2 || REPEAT_TICKS < 1 || SCAN_DIV < 2) begin : g_param_chk
    $error("keypad_scan_debounce: DEB_TICKS>=2, REPEAT_TICKS>=1, SCAN_DIV>=2 required");
  end

  logic [3:0]    row_m, row_s, row_lat, row_lat_nxt;
  logic [1:0]    cidx, cidx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    col_nxt;
  logic          flag_nxt, held_nxt, tick;
  logic [3:0]    value_nxt;
  state_t        state, state_nxt;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rpt, rpt_nxt;
`endif

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_m     <= '0;
      row_s     <= '0;
      row_lat   <= '0;
      cidx      <= '0;
      cnt       <= '0;
      col       <= COL_RST;
      key_flag  <= 1'b0;
      key_value <= KEY_0;
      key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      row_m     <= row;
      row_s     <= row_m;
      row_lat   <= row_lat_nxt;
      cidx      <= cidx_nxt;
      cnt       <= cnt_nxt;
      col       <= col_nxt;
      key_flag  <= flag_nxt;
      key_value <= value_nxt;
      key_held  <= held_nxt;
`ifdef KEY_REPEAT_EN
      rpt       <= rpt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    row_lat_nxt = row_lat;
    cidx_nxt    = cidx;
    cnt_nxt     = cnt;
    col_nxt     = col;
    flag_nxt    = 1'b0;
    value_nxt   = key_value;
    held_nxt    = key_held;
`ifdef KEY_REPEAT_EN
    rpt_nxt     = rpt;
`endif
    case (state)
      SCAN: if (tick) begin
        // Multi-row (ghost/combination) samples are treated as no key.
        if ($onehot(row_s)) begin
          row_lat_nxt = row_s;
          cidx_nxt    = onehot_index({1'b0, col});
          cnt_nxt     = CW'(1);
          state_nxt   = DEBOUNCE;
        end else begin
          col_nxt = {col[1:0], col[2]};
        end
      end
      DEBOUNCE: if (tick) begin
        if (row_s == row_lat) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == CW'(DEB_TICKS)) begin
            state_nxt = PRESSED;
            flag_nxt  = 1'b1;
            value_nxt = key_map(onehot_index(row_lat), cidx);
            held_nxt  = 1'b1;
          end
        end else begin
          state_nxt = SCAN;
          col_nxt   = {col[1:0], col[2]};
        end
      end
      PRESSED: begin
        cnt_nxt   = '0;
        state_nxt = HOLD;
`ifdef KEY_REPEAT_EN
        rpt_nxt   = '0;
`endif
      end
      HOLD: if (tick) begin
        if (row_s == 4'b0000) begin
          cnt_nxt = cnt + CW'(1);
`ifdef KEY_REPEAT_EN
          rpt_nxt = '0;
`endif
          if (cnt_nxt == CW'(DEB_TICKS)) begin
            cnt_nxt   = '0;
            held_nxt  = 1'b0;
            state_nxt = SCAN;
          end
        end else begin
          cnt_nxt = '0;
`ifdef KEY_REPEAT_EN
          if (rpt + RW'(1) == RW'(REPEAT_TICKS)) begin
            rpt_nxt  = '0;
            flag_nxt = 1'b1;
          end else begin
            rpt_nxt = rpt + RW'(1);
          end
`endif
        end
      end
      default: state_nxt = SCAN;
    endcase
  end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench: keypad modelled as a switch matrix driving rows from the
// DUT column strobe; a tick-level reference model is compared every cycle.
module tb_keypad_scan_debounce;
  localparam int SCAN_DIV = 4, DEB_TICKS = 3, REPEAT_TICKS = 5;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] row;
  logic [2:0] col;
  logic       key_flag, key_held;
  logic [3:0] key_value;
  logic [11:0] pressed = '0;  // bit r*3+c = key at row r, column c is down

  int passed = 0, total = 0, flag_cnt = 0, base = 0;

  keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS),
                         .REPEAT_TICKS(REPEAT_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_flag(key_flag), .key_value(key_value), .key_held(key_held));

  always #5 clk = ~clk;

  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) row[r] = |(pressed[r*3 +: 3] & col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (tick-level keypad semantics) ----------------
  int keymap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
  int m_div, m_col, m_cand, m_streak, m_rel, m_rpt, m_val, k;
  bit m_held, m_gap, m_flag, tk;
  logic [3:0] m_r1, m_r2, rs;

  function automatic int decode(input logic [3:0] v, input int c);
    int n, r;
    n = 0; r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) begin n++; r = i; end
    if (n != 1) return -1;
    return keymap[r][c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div = 0; m_col = 0; m_cand = -1; m_streak = 0; m_rel = 0; m_rpt = 0; m_val = 0;
      m_held = 0; m_gap = 0; m_flag = 0; m_r1 = '0; m_r2 = '0;
    end else begin
      rs = m_r2; m_r2 = m_r1; m_r1 = row;
      tk = (m_div == SCAN_DIV - 1);
      m_div = tk ? 0 : m_div + 1;
      m_flag = 0;
      k = decode(rs, m_col);
      if (m_gap) m_gap = 0;
      else if (tk) begin
        if (m_held) begin
          if (rs == 0) begin
            m_rpt = 0;
            m_rel++;
            if (m_rel == DEB_TICKS) begin m_held = 0; m_cand = -1; m_rel = 0; end
          end else begin
            m_rel = 0;
`ifdef KEY_REPEAT_EN
            m_rpt++;
            if (m_rpt == REPEAT_TICKS) begin m_flag = 1; m_rpt = 0; end
`endif
          end
        end else if (m_cand < 0) begin
          if (k >= 0) begin m_cand = k; m_streak = 1; end
          else m_col = (m_col + 1) % 3;
        end else if (k == m_cand) begin
          m_streak++;
          if (m_streak == DEB_TICKS) begin
            m_flag = 1; m_val = k; m_held = 1; m_gap = 1; m_rel = 0; m_rpt = 0;
          end
        end else begin
          m_cand = -1;
          m_col = (m_col + 1) % 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (key_flag) flag_cnt++;
    if (rst_n) begin
      check("col", col, 32'(1 << m_col));
      check("key_flag", key_flag, m_flag);
      check("key_value", key_value, m_val);
      check("key_held", key_held, m_held);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic wait_col(input logic [2:0] c);
    for (int i = 0; i < 60 && col !== c; i++) @(negedge clk);
    check("wait_col", col, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_col", col, 3'b001);
    check("rst_flag", key_flag, 1'b0);
    check("rst_value", key_value, 4'h0);
    check("rst_held", key_held, 1'b0);
    rst_n = 1'b1;

    // idle rotation, 4 clocks per column slot
    wait_col(3'b010);
    repeat (4) @(negedge clk);
    check("rot_100", col, 3'b100);
    repeat (4) @(negedge clk);
    check("rot_001", col, 3'b001);
    check("idle_flags", flag_cnt, 0);
    check("idle_value", key_value, 4'h0);

    // key 6 (row1, col2) held for 10 ticks
    base = flag_cnt;
    pressed[5] = 1'b1;
    repeat (40) @(negedge clk);
    check("k6_flags", flag_cnt - base, 1);
    check("k6_value", key_value, 4'h6);
    check("k6_held", key_held, 1'b1);
    check("k6_col", col, 3'b100);
    pressed = '0;
    repeat (20) @(negedge clk);
    check("k6_released", key_held, 1'b0);
    check("k6_value_kept", key_value, 4'h6);

    // bounce: key 0 (row3, col1) visible for only 2 ticks, five times
    base = flag_cnt;
    for (int n = 0; n < 5; n++) begin
      wait_col(3'b001);
      wait_col(3'b010);
      pressed[10] = 1'b1;
      repeat (8) @(negedge clk);
      pressed = '0;
      repeat (2) @(negedge clk);
    end
    check("bounce_flags", flag_cnt - base, 0);
    wait_col(3'b001);
    wait_col(3'b010);

    // two rows in column 0 (keys 1 and *): row = 4'b1001, not a key
    base = flag_cnt;
    pressed[0] = 1'b1;
    pressed[9] = 1'b1;
    repeat (30) @(negedge clk);
    check("multi_flags", flag_cnt - base, 0);
    check("multi_held", key_held, 1'b0);
    wait_col(3'b100);
    pressed = '0;
    repeat (4) @(negedge clk);

    // '#' then reset while held
    pressed[11] = 1'b1;
    for (int i = 0; i < 80 && !key_held; i++) @(negedge clk);
    check("hash_held", key_held, 1'b1);
    check("hash_value", key_value, 4'hB);
    repeat (6) @(negedge clk);
    base = flag_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_col", col, 3'b001);
    check("mid_rst_flag", key_flag, 1'b0);
    check("mid_rst_value", key_value, 4'h0);
    check("mid_rst_held", key_held, 1'b0);
    repeat (3) @(negedge clk);
    pressed = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_flags", flag_cnt - base, 0);
    check("post_rst_value", key_value, 4'h0);

`ifdef KEY_REPEAT_EN
    // '*' held 20 ticks past acceptance: acceptance + 4 repeats
    base = flag_cnt;
    pressed[9] = 1'b1;
    for (int i = 0; i < 80 && !key_flag; i++) @(negedge clk);
    check("star_accept", key_flag, 1'b1);
    repeat (80) @(posedge clk);
    @(negedge clk);
    pressed = '0;
    repeat (20) @(negedge clk);
    check("star_flags", flag_cnt - base, 5);
    check("star_value", key_value, 4'hA);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
